time_counter_hms_cfg: RTL and testbench

Configurable successor to the HH:MM:SS BCD time counter, sitting between the 1 Hz tick generator / button debouncers and the display mux.
- Runs as a wall clock counting up, or as a countdown timer that stops at 00:00:00 and flags completion.
- Supports a validated parallel BCD load, field-local adjust pulses that do not carry, a run/pause gate, and a 12-hour display view with a PM flag.
- Reset values are set by parameters.

---
 rtl/time_counter_hms_cfg.sv | 98 +++++++++
 tb/tb_time_counter_hms_cfg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/time_counter_hms_cfg.sv
// time_counter_hms_cfg: HH:MM:SS BCD clock/countdown with load, adjust, pause and 12h view
module time_counter_hms_cfg #(
  parameter int RST_HOUR = 0,
  parameter int RST_MIN = 0,
  parameter int RST_SEC = 0,
  parameter int EN_12H = 1
) (
  input  logic       clk,
  input  logic       clr_time,
  input  logic       tick_1hz,
  input  logic       count_en,
  input  logic       mode_timer,
  input  logic       mode_12h,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       load,
  input  logic [1:0] ld_hour_tens,
  input  logic [3:0] ld_hour_ones,
  input  logic [3:0] ld_min_tens,
  input  logic [3:0] ld_min_ones,
  input  logic [3:0] ld_sec_tens,
  input  logic [3:0] ld_sec_ones,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hour_ones,
  output logic [1:0] hour_tens,
  output logic [1:0] disp_hour_tens,
  output logic [3:0] disp_hour_ones,
  output logic       pm,
  output logic       day_pulse,
  output logic       done,
  output logic       load_err
);
  logic [4:0] h, nh, dh;
  logic [5:0] m, s, nm, ns;
  logic zero, t, cs, cm, ch, bs, bm, valid, take;
  assign h = 5'(hour_tens) * 5'd10 + 5'(hour_ones);
  assign m = 6'(min_tens) * 6'd10 + 6'(min_ones);
  assign s = 6'(sec_tens) * 6'd10 + 6'(sec_ones);
  // effective tick, carry/borrow chain, field-local next values and load validation
  always_comb begin
    zero = h == 5'd0 && m == 6'd0 && s == 6'd0;
    t = tick_1hz & count_en & ~(mode_timer & zero);
    cs = t & ~mode_timer & (s == 6'd59);
    cm = cs & (m == 6'd59);
    ch = cm & (h == 5'd23);
    bs = t & mode_timer & (s == 6'd0);
    bm = bs & (m == 6'd0);
    ns = 6'((7'(s) + 7'd60 + 7'(t & ~mode_timer) - 7'(t & mode_timer) + 7'(inc_sec)) % 7'd60);
    nm = 6'((7'(m) + 7'd60 + 7'(cs) - 7'(bs) + 7'(inc_min)) % 7'd60);
    nh = 5'((7'(h) + 7'd24 + 7'(cm) - 7'(bm) + 7'(inc_hour)) % 7'd24);
    valid = ld_hour_ones <= 4'd9 && ld_min_ones <= 4'd9 && ld_sec_ones <= 4'd9 &&
            ld_min_tens <= 4'd5 && ld_sec_tens <= 4'd5 &&
            (ld_hour_tens < 2'd2 || (ld_hour_tens == 2'd2 && ld_hour_ones <= 4'd3));
    take = load & valid;
  end
  // time registers and one-cycle flags; a valid load swallows tick and adjust
  always_ff @(posedge clk) begin
    if (clr_time) begin
      hour_tens <= 2'(RST_HOUR / 10);
      hour_ones <= 4'(RST_HOUR % 10);
      min_tens <= 4'(RST_MIN / 10);
      min_ones <= 4'(RST_MIN % 10);
      sec_tens <= 4'(RST_SEC / 10);
      sec_ones <= 4'(RST_SEC % 10);
      day_pulse <= 1'b0;
      done <= 1'b0;
      load_err <= 1'b0;
    end else if (take) begin
      hour_tens <= ld_hour_tens;
      hour_ones <= ld_hour_ones;
      min_tens <= ld_min_tens;
      min_ones <= ld_min_ones;
      sec_tens <= ld_sec_tens;
      sec_ones <= ld_sec_ones;
      day_pulse <= 1'b0;
      done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      hour_tens <= 2'(nh / 5'd10);
      hour_ones <= 4'(nh % 5'd10);
      min_tens <= 4'(nm / 6'd10);
      min_ones <= 4'(nm % 6'd10);
      sec_tens <= 4'(ns / 6'd10);
      sec_ones <= 4'(ns % 6'd10);
      day_pulse <= ch;
      done <= t & mode_timer & (nh == 5'd0) & (nm == 6'd0) & (ns == 6'd0);
      load_err <= load;
    end
  end
  assign dh = (EN_12H != 0 && mode_12h) ? (h == 5'd0 ? 5'd12 : h > 5'd12 ? h - 5'd12 : h) : h;
  assign pm = EN_12H != 0 && mode_12h && h >= 5'd12;
  assign disp_hour_tens = 2'(dh / 5'd10);
  assign disp_hour_ones = 4'(dh % 5'd10);
endmodule

// File: tb/tb_time_counter_hms_cfg.sv
// tb_time_counter_hms_cfg: directed bench with a seconds-of-day model checked every cycle
module tb_time_counter_hms_cfg;
  logic clk = 0, clr_time = 0, tick_1hz = 0, count_en = 1, mode_timer = 0, mode_12h = 0;
  logic inc_hour = 0, inc_min = 0, inc_sec = 0, load = 0;
  logic [1:0] ld_hour_tens = 0;
  logic [3:0] ld_hour_ones = 0, ld_min_tens = 0, ld_min_ones = 0, ld_sec_tens = 0, ld_sec_ones = 0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, disp_hour_ones;
  logic [1:0] hour_tens, disp_hour_tens;
  logic pm, day_pulse, done, load_err;
  logic [3:0] sec_ones2, sec_tens2, min_ones2, min_tens2, hour_ones2, disp_hour_ones2;
  logic [1:0] hour_tens2, disp_hour_tens2;
  logic pm2, day_pulse2, done2, load_err2;
  int pass_cnt = 0, total = 0;
  int tsec = 0;
  bit mvalid = 0, mdp = 0, mdone = 0, merr = 0;

  always #5 clk = ~clk;

  time_counter_hms_cfg #(.RST_HOUR(9), .RST_MIN(30), .RST_SEC(0), .EN_12H(1)) dut (
    .clk(clk), .clr_time(clr_time), .tick_1hz(tick_1hz), .count_en(count_en),
    .mode_timer(mode_timer), .mode_12h(mode_12h), .inc_hour(inc_hour), .inc_min(inc_min),
    .inc_sec(inc_sec), .load(load), .ld_hour_tens(ld_hour_tens), .ld_hour_ones(ld_hour_ones),
    .ld_min_tens(ld_min_tens), .ld_min_ones(ld_min_ones), .ld_sec_tens(ld_sec_tens),
    .ld_sec_ones(ld_sec_ones), .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hour_ones(hour_ones), .hour_tens(hour_tens),
    .disp_hour_tens(disp_hour_tens), .disp_hour_ones(disp_hour_ones), .pm(pm),
    .day_pulse(day_pulse), .done(done), .load_err(load_err));

  time_counter_hms_cfg #(.RST_HOUR(9), .RST_MIN(30), .RST_SEC(0), .EN_12H(0)) dut2 (
    .clk(clk), .clr_time(clr_time), .tick_1hz(tick_1hz), .count_en(count_en),
    .mode_timer(mode_timer), .mode_12h(mode_12h), .inc_hour(inc_hour), .inc_min(inc_min),
    .inc_sec(inc_sec), .load(load), .ld_hour_tens(ld_hour_tens), .ld_hour_ones(ld_hour_ones),
    .ld_min_tens(ld_min_tens), .ld_min_ones(ld_min_ones), .ld_sec_tens(ld_sec_tens),
    .ld_sec_ones(ld_sec_ones), .sec_ones(sec_ones2), .sec_tens(sec_tens2), .min_ones(min_ones2),
    .min_tens(min_tens2), .hour_ones(hour_ones2), .hour_tens(hour_tens2),
    .disp_hour_tens(disp_hour_tens2), .disp_hour_ones(disp_hour_ones2), .pm(pm2),
    .day_pulse(day_pulse2), .done(done2), .load_err(load_err2));

  function automatic int dut_hms();
    return (int'(hour_tens) * 10 + int'(hour_ones)) * 10000 +
           (int'(min_tens) * 10 + int'(min_ones)) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  function automatic int dut2_hms();
    return (int'(hour_tens2) * 10 + int'(hour_ones2)) * 10000 +
           (int'(min_tens2) * 10 + int'(min_ones2)) * 100 + int'(sec_tens2) * 10 + int'(sec_ones2);
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  // model: time as seconds of day; ticks move the whole value, adjusts move one field modulo
  always @(posedge clk) begin
    int h, m, s, t;
    bit v;
    if (clr_time) begin
      tsec = 9 * 3600 + 30 * 60;
      mdp = 0; mdone = 0; merr = 0; mvalid = 1;
    end else begin
      v = ld_hour_ones <= 9 && ld_min_ones <= 9 && ld_sec_ones <= 9 && ld_min_tens <= 5 &&
          ld_sec_tens <= 5 && (int'(ld_hour_tens) * 10 + int'(ld_hour_ones)) <= 23;
      mdp = 0; mdone = 0;
      merr = load && !v;
      if (load && v) begin
        tsec = (int'(ld_hour_tens) * 10 + int'(ld_hour_ones)) * 3600 +
               (int'(ld_min_tens) * 10 + int'(ld_min_ones)) * 60 + int'(ld_sec_tens) * 10 + int'(ld_sec_ones);
      end else begin
        t = (tick_1hz && count_en && !(mode_timer && tsec == 0)) ? 1 : 0;
        if (t == 1) begin
          if (!mode_timer) begin
            mdp = tsec == 86399;
            tsec = (tsec + 1) % 86400;
          end else tsec = tsec - 1;
        end
        h = (tsec / 3600 + int'(inc_hour)) % 24;
        m = (tsec / 60 % 60 + int'(inc_min)) % 60;
        s = (tsec % 60 + int'(inc_sec)) % 60;
        tsec = h * 3600 + m * 60 + s;
        mdone = mode_timer && t == 1 && tsec == 0;
      end
    end
  end

  // compare every cycle once the model has been reset
  always @(negedge clk) begin
    int h, eh;
    if (mvalid) begin
      h = tsec / 3600;
      eh = mode_12h ? (h == 0 ? 12 : h > 12 ? h - 12 : h) : h;
      chk("time", dut_hms(), h * 10000 + tsec / 60 % 60 * 100 + tsec % 60);
      chk("flags", {day_pulse, done, load_err}, {mdp, mdone, merr});
      chk("disp", int'(disp_hour_tens) * 10 + int'(disp_hour_ones) + (pm ? 100 : 0),
          eh + ((mode_12h && h >= 12) ? 100 : 0));
      chk("time2", dut2_hms(), h * 10000 + tsec / 60 % 60 * 100 + tsec % 60);
      chk("disp2", int'(disp_hour_tens2) * 10 + int'(disp_hour_ones2) + (pm2 ? 100 : 0), h);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    clr_time = 0; tick_1hz = 0; inc_hour = 0; inc_min = 0; inc_sec = 0; load = 0;
  endtask

  task automatic ld(input int ht, input int ho, input int mt, input int mo, input int st, input int so);
    load = 1;
    ld_hour_tens = 2'(ht); ld_hour_ones = 4'(ho); ld_min_tens = 4'(mt);
    ld_min_ones = 4'(mo); ld_sec_tens = 4'(st); ld_sec_ones = 4'(so);
  endtask

  task automatic dsp(input int hh, input int ed, input bit epm);
    ld(hh / 10, hh % 10, 0, 0, 0, 0);
    cyc();
    chk("disp12", int'(disp_hour_tens) * 10 + int'(disp_hour_ones), ed);
    chk("pm12", int'(pm), int'(epm));
    chk("disp24", int'(disp_hour_tens2) * 10 + int'(disp_hour_ones2), hh);
    chk("pm24", int'(pm2), 0);
  endtask

  initial begin
    #2;
    clr_time = 1; cyc();
    chk("rst_time", dut_hms(), 93000);
    chk("rst_flags", {day_pulse, done, load_err}, 0);
    repeat (3) begin tick_1hz = 1; cyc(); end
    chk("count3", dut_hms(), 93003);
    clr_time = 1; tick_1hz = 1; cyc();
    chk("clr_mid", dut_hms(), 93000);
    ld(2, 3, 5, 9, 5, 9); cyc();
    tick_1hz = 1; cyc();
    chk("wrap", dut_hms(), 0);
    chk("day_pulse", int'(day_pulse), 1);
    cyc();
    chk("day_pulse_1cyc", int'(day_pulse), 0);
    ld(2, 3, 5, 9, 5, 9); cyc();
    count_en = 0; tick_1hz = 1; cyc();
    chk("paused", dut_hms(), 235959);
    inc_sec = 1; cyc();
    chk("paused_adj", dut_hms(), 235900);
    count_en = 1;
    ld(1, 2, 5, 9, 5, 9); cyc();
    tick_1hz = 1; inc_min = 1; cyc();
    chk("tick_inc_min", dut_hms(), 130100);
    ld(2, 3, 1, 5, 3, 0); cyc();
    inc_hour = 1; cyc();
    chk("inc_hour_wrap", dut_hms(), 1530);
    chk("inc_hour_no_dp", int'(day_pulse), 0);
    inc_min = 1; ld(1, 2, 6, 0, 0, 0); cyc();
    chk("bad_min_time", dut_hms(), 1630);
    chk("bad_min_err", int'(load_err), 1);
    cyc();
    chk("err_1cyc", int'(load_err), 0);
    tick_1hz = 1; ld(2, 4, 0, 0, 0, 0); cyc();
    chk("bad_hour_time", dut_hms(), 1631);
    chk("bad_hour_err", int'(load_err), 1);
    tick_1hz = 1; inc_hour = 1; ld(0, 5, 0, 6, 0, 7); cyc();
    chk("load_tick", dut_hms(), 50607);
    mode_timer = 1;
    ld(0, 0, 0, 1, 0, 0); cyc();
    repeat (60) begin tick_1hz = 1; cyc(); end
    chk("cd_zero", dut_hms(), 0);
    chk("cd_done", int'(done), 1);
    tick_1hz = 1; cyc();
    chk("cd_hold", dut_hms(), 0);
    chk("cd_hold_done", int'(done), 0);
    ld(0, 0, 0, 0, 5, 9); cyc();
    inc_sec = 1; cyc();
    chk("adj_zero", dut_hms(), 0);
    chk("adj_zero_done", int'(done), 0);
    ld(0, 1, 0, 0, 0, 0); cyc();
    tick_1hz = 1; cyc();
    chk("borrow", dut_hms(), 5959);
    mode_timer = 0;
    mode_12h = 1;
    dsp(0, 12, 0);
    dsp(11, 11, 0);
    dsp(12, 12, 1);
    dsp(13, 1, 1);
    dsp(23, 11, 1);
    mode_12h = 0;
    dsp(13, 13, 0);
    cyc();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
